// File: rtl/i2c_bus_recovery.sv
// I2C bus-clear sequencer: clocks SCL until a stuck slave releases SDA, then issues a STOP.
// Define I2C_RECOVERY_STRETCH_EN to honour slave clock stretching with a bounded wait.
module i2c_bus_recovery #(
    parameter int unsigned HALF_PERIOD = 250,
    parameter int unsigned MAX_PULSES  = 9
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] pulse_count
);
    localparam int unsigned CW = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] CntLast = CW'(HALF_PERIOD - 1);
    localparam logic [3:0] PulseMax = 4'(MAX_PULSES);

    typedef enum logic [3:0] {
        StIdle, StCheck, StSclLow, StSclHigh,
        StStopA, StStopB, StStopC, StStopD, StDone, StFail
    } state_e;

    state_e        state, state_next;
    logic [CW-1:0] cnt;
    logic          trig_d, sda_m, sda_s;
    logic          edge_seen, phase_end, high_end, stall, stretch_to;
    logic [3:0]    pulse_inc;

`ifdef I2C_RECOVERY_STRETCH_EN
    localparam int unsigned SW = $clog2(4 * HALF_PERIOD);
    localparam logic [SW-1:0] StretchLast = SW'(4 * HALF_PERIOD - 1);

    logic          scl_m, scl_s;
    logic [SW-1:0] stretch_cnt;

    // Stretch budget counts consecutive low cycles of SCL in a released-SCL state.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            scl_m       <= 1'b1;
            scl_s       <= 1'b1;
            stretch_cnt <= '0;
        end else begin
            scl_m <= scl_in;
            scl_s <= scl_m;
            if (state_next != state || !stall) begin
                stretch_cnt <= '0;
            end else if (stretch_cnt != StretchLast) begin
                stretch_cnt <= stretch_cnt + SW'(1);
            end
        end
    end

    assign stall      = (state == StSclHigh || state == StStopC || state == StStopD) && !scl_s;
    assign stretch_to = stall && (stretch_cnt == StretchLast);
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign stall      = 1'b0;
    assign stretch_to = 1'b0;
`endif

    assign edge_seen = trigger & ~trig_d;
    assign phase_end = (cnt == CntLast);
    assign high_end  = (state == StSclHigh) && phase_end && !stall;
    assign pulse_inc = (pulse_count >= PulseMax) ? PulseMax : pulse_count + 4'd1;

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:    if (edge_seen) state_next = StCheck;
            StCheck:   state_next = sda_s ? StStopA : StSclLow;
            StSclLow:  if (phase_end) state_next = StSclHigh;
            StSclHigh: begin
                if (stretch_to) begin
                    state_next = StFail;
                end else if (high_end) begin
                    // SDA release takes priority over hitting the pulse limit.
                    if (sda_s)                        state_next = StStopA;
                    else if (pulse_inc == PulseMax)   state_next = StFail;
                    else                              state_next = StSclLow;
                end
            end
            StStopA:   if (phase_end) state_next = StStopB;
            StStopB:   if (phase_end) state_next = StStopC;
            StStopC: begin
                if (stretch_to)                  state_next = StFail;
                else if (phase_end && !stall)    state_next = StStopD;
            end
            StStopD: begin
                if (stretch_to)                  state_next = StFail;
                else if (phase_end && !stall)    state_next = StDone;
            end
            StDone:    state_next = StIdle;
            StFail:    state_next = StIdle;
            default:   state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            trig_d      <= 1'b0;
            sda_m       <= 1'b1;
            sda_s       <= 1'b1;
            pulse_count <= 4'd0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            trig_d <= trigger;
            sda_m  <= sda_in;
            sda_s  <= sda_m;
            state  <= state_next;

            if (state_next != state || stall) begin
                cnt <= '0;
            end else if (!phase_end) begin
                cnt <= cnt + CW'(1);
            end

            if (state == StIdle && edge_seen) begin
                pulse_count <= 4'd0;
            end else if (high_end && !stretch_to) begin
                pulse_count <= pulse_inc;
            end

            // Outputs are decoded from the next state so they change with the state register.
            scl_oe <= (state_next == StSclLow) || (state_next == StStopA) ||
                      (state_next == StStopB);
            sda_oe <= (state_next == StStopB) || (state_next == StStopC);
            busy   <= (state_next != StIdle);
            done   <= (state_next == StDone);
            fail   <= (state_next == StFail);
        end
    end
endmodule
